// File: rtl/uart_rx_ring_pkg.sv
// Shared UART parameters: default word size, ring depth, bit period and the
// receive FSM state encoding. Used by both the RX front end and the ring.
package uart_rx_ring_pkg;

  localparam int WORD_SIZE_p    = 8;
  localparam int RX_RING_SIZE_p = 8;
  localparam int CLKS_PER_BIT_p = 434;  // 50 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_ring_fifo.sv
// Power-of-two ring buffer shared by the UART RX and TX paths.
// Head/tail wrap naturally; a push and a pop on the same edge both succeed,
// even when full. A push into a full ring without a pop is dropped and
// reported through a one-cycle overflow pulse.
module uart_ring_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] ring_mem [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             not_empty_q, not_empty_d;
  logic             overflow_q, overflow_d;
  logic             pop_ok, push_ok;

  // Pointer, occupancy and status next-state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pop_ok      = pop && not_empty_q;
    push_ok     = push && ((count_q != CNT_FULL) || pop_ok);
    overflow_d  = push && !push_ok;
    if (pop_ok)  head_d = head_q + PTR_ONE;
    if (push_ok) tail_d = tail_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    not_empty_d = (count_d != '0);
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      not_empty_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      not_empty_q <= not_empty_d;
      overflow_q  <= overflow_d;
    end
  end

  // Word storage.
  // NOTE: storage is not reset; occupancy gates visibility, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (push_ok) ring_mem[tail_q] <= push_data;
  end

  assign head_data = not_empty_q ? ring_mem[head_q] : '0;
  assign not_empty = not_empty_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/uart_rx_ring.sv
// UART receiver feeding a ring buffer read by the host.
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
// between the data bits and the stop bit; otherwise parity_err is tied low.
module uart_rx_ring
  import uart_rx_ring_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_p,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_p,
  parameter int RX_RING_SIZE = RX_RING_SIZE_p
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 read_nic,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 read_nic_i,
  output logic                 frame_err,
  output logic                 overflow,
  output logic                 parity_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WORD_SIZE + 1);
  localparam logic [TW-1:0] HALF_TICK = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_SIZE - 1);

  logic                 sync_q, rxs_q, rxs_prev_q;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 push;
  logic                 tick_full;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  // NOTE: these reset to 1 (line idle) so leaving reset never looks like a start edge by itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= rx;
      rxs_q      <= sync_q;
      rxs_prev_q <= rxs_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad_q, parity_bad_d;
  logic parity_err_q, parity_err_d;
`endif

  // Receive FSM: next state, bit timer, shift register and error strobes.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + TIMER_ONE;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    tick_full   = (timer_q == FULL_TICK);
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rxs_prev_q && !rxs_q) state_d = START;
      end
      START: begin
        if (timer_q == HALF_TICK) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rxs_q ? IDLE : DATA;  // high at mid-start is a glitch
        end
      end
      DATA: begin
        if (tick_full) begin
          timer_d                = '0;
          shift_d                = shift_q >> 1;
          shift_d[WORD_SIZE-1]   = rxs_q;  // LSB arrives first
          bit_cnt_d              = bit_cnt_q + BIT_ONE;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          timer_d      = '0;
          parity_bad_d = ((^shift_q) != rxs_q);  // even parity over data + parity bit
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          timer_d = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_d = parity_bad_q;
          parity_bad_d = 1'b0;
          push         = rxs_q && !parity_bad_q;
`else
          push         = rxs_q;
`endif
          frame_err_d = !rxs_q;
          state_d     = rxs_q ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        timer_d = '0;
        if (rxs_q) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity flag and its one-cycle error strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  uart_ring_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (RX_RING_SIZE)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_q),
    .pop       (read_nic),
    .head_data (data_out),
    .not_empty (read_nic_i),
    .overflow  (overflow)
  );

  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ring.sv
// Directed bench for uart_rx_ring with a word scoreboard: stimulus pushes the
// words it expects to read back, and a monitor pops and compares every time
// the host actually pops a word. Error strobes are counted by the monitor.
module tb_uart_rx_ring;
  import uart_rx_ring_pkg::*;

  localparam int WS    = 8;
  localparam int CPB   = 256;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx = 1'b1;
  logic          read_nic = 1'b0;
  logic [WS-1:0] data_out;
  logic          read_nic_i;
  logic          frame_err;
  logic          overflow;
  logic          parity_err;

  always #5 clk = ~clk;

  uart_rx_ring #(
    .WORD_SIZE    (WS),
    .CLKS_PER_BIT (CPB),
    .RX_RING_SIZE (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .read_nic   (read_nic),
    .data_out   (data_out),
    .read_nic_i (read_nic_i),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  int            pass_cnt = 0;
  int            check_cnt = 0;
  logic [WS-1:0] exp_q[$];
  int            frame_err_seen = 0;
  int            overflow_seen = 0;
  int            parity_err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: count error strobes and score every popped word.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err)  frame_err_seen++;
      if (overflow)   overflow_seen++;
      if (parity_err) parity_err_seen++;
      if (read_nic && read_nic_i) begin
        if (exp_q.size() == 0) check("scoreboard_depth_at_pop", exp_q.size(), 1);
        else check("popped_word", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [WS-1:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < WS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic do_read();
    read_nic = 1'b1;
    tick(1);
    read_nic = 1'b0;
    tick(1);
  endtask

  int  cycles;
  int  fe0, ov0, pe0;
  bit  found;

  initial begin
    // Reset state.
    tick(3);
    check("reset_data_out", data_out, 0);
    check("reset_read_nic_i", read_nic_i, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overflow", overflow, 0);
    check("reset_parity_err", parity_err, 0);
    rst = 1'b1;
    tick(5);

    // Pop while empty is ignored.
    do_read();
    check("empty_pop_count", dut.u_ring.count_q, 0);
    check("empty_pop_valid", read_nic_i, 0);

    // Good frame 0xA5: latency to read_nic_i, data, single pop empties.
    exp_q.push_back(8'hA5);
    cycles = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!read_nic_i && cycles < CPB * 11) begin
          tick(1);
          cycles++;
        end
      end
    join
    // Stop sampled mid-bit (9.5 bit periods) plus 2 sync flops; allow 2 more.
    check("a5_latency_in_window",
          (cycles >= 9 * CPB + CPB / 2) && (cycles <= 9 * CPB + CPB / 2 + 4), 1);
    check("a5_data_out", data_out, 8'hA5);
    do_read();
    check("a5_empty_after_pop", read_nic_i, 0);
    check("a5_data_out_zero", data_out, 0);

    // Short low glitch: no push, no error, back to IDLE.
    fe0 = frame_err_seen;
    rx = 1'b0;
    tick(100);
    rx = 1'b1;
    tick(CPB);
    check("glitch_no_frame_err", frame_err_seen - fe0, 0);
    check("glitch_no_push", read_nic_i, 0);
    check("glitch_state_idle", 32'(dut.state_q), 32'(IDLE));

    // Bad stop bit, then a good frame.
    fe0 = frame_err_seen;
    send_frame(8'h3C, 1'b0);
    tick(4);
    check("stop0_frame_err_once", frame_err_seen - fe0, 1);
    check("stop0_ring_empty", read_nic_i, 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick(2);
    check("after_err_valid", read_nic_i, 1);
    check("after_err_data", data_out, 8'h11);
    do_read();

    // Nine words into depth eight: 0x09 dropped with one overflow pulse.
    ov0 = overflow_seen;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      tick(2);
    end
    check("fill_no_overflow", overflow_seen - ov0, 0);
    send_frame(8'h09, 1'b1);
    tick(2);
    check("overflow_once_on_9", overflow_seen - ov0, 1);
    check("overflow_count_8", dut.u_ring.count_q, 8);
    check("overflow_head_kept", data_out, 8'h01);
    for (int i = 0; i < 8; i++) do_read();
    check("drained_valid", read_nic_i, 0);

    // Full ring, push and pop on the same edge.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      send_frame(8'h20 + 8'(i), 1'b1);
      tick(2);
    end
    check("full_before_collide", dut.u_ring.count_q, 8);
    ov0 = overflow_seen;
    exp_q.push_back(8'h28);
    found = 1'b0;
    fork
      send_frame(8'h28, 1'b1);
      begin
        for (int c = 0; c < CPB * 12 && !found; c++) begin
          tick(1);
          if (dut.state_q == STOP && int'(dut.timer_q) == CPB - 1) begin
            read_nic = 1'b1;
            tick(1);
            read_nic = 1'b0;
            found = 1'b1;
          end
        end
      end
    join
    tick(2);
    check("collide_found_push_cycle", found, 1);
    check("collide_no_overflow", overflow_seen - ov0, 0);
    check("collide_count_8", dut.u_ring.count_q, 8);
    check("collide_head", data_out, 8'h21);
    for (int i = 0; i < 8; i++) do_read();
    check("collide_drained", read_nic_i, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones; even parity needs 1, send 0.
    pe0 = parity_err_seen;
    fe0 = frame_err_seen;
    drive_bit(1'b0);
    for (int i = 0; i < WS; i++) drive_bit(i < 3);
    drive_bit(1'b0);
    drive_bit(1'b1);
    tick(2);
    check("parity_err_once", parity_err_seen - pe0, 1);
    check("parity_no_frame_err", frame_err_seen - fe0, 0);
    check("parity_word_dropped", read_nic_i, 0);
`endif

    // Reset mid-frame with a word waiting in the ring.
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(2);
    check("pre_reset_valid", read_nic_i, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_read_nic_i", read_nic_i, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("rst_count_zero", dut.u_ring.count_q, 0);
    exp_q.delete();
    rx = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(CPB * 2);
    check("post_rst_empty", read_nic_i, 0);
    exp_q.push_back(8'h6B);
    send_frame(8'h6B, 1'b1);
    tick(2);
    check("post_rst_rx_data", data_out, 8'h6B);
    do_read();

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef UART_RX_PARITY_EN
    check("parity_err_total", parity_err_seen, 1);
`else
    check("parity_err_total", parity_err_seen, 0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Watchdog bound on the whole run.
  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget, got %0d/%0d", pass_cnt, check_cnt);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_ring.md
UART_RX_RING -- requirements
Module: uart_rx_ring

Interface
REQ-001 SHALL take parameter WORD_SIZE, default 8, data bits per frame.
REQ-002 SHALL take parameter CLKS_PER_BIT, default 434, clk cycles per bit (50 MHz / 115200).
REQ-003 SHALL take parameter RX_RING_SIZE, default 8, ring depth; power of two, at least 2.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named as the codebase does:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have the remaining ports:
- rx  input  1  serial line; idles high; asynchronous to clk.
- read_nic  input  1  pop request from the host.
- data_out  output  WORD_SIZE  oldest unread word (ring head).
- read_nic_i  output  1  ring non-empty; data_out valid.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- overflow  output  1  one-cycle pulse when a good word is dropped because the ring is full.
- parity_err  output  1  one-cycle pulse on a parity mismatch.

Function
REQ-006 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-007 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-008 In IDLE, a 1->0 edge on rxs SHALL move the FSM to START and clear the bit-timer.
REQ-009 In START, rxs SHALL be sampled at count CLKS_PER_BIT/2-1: low -> DATA with timer reset; high -> IDLE (glitch, no error).
REQ-010 In DATA, rxs SHALL be sampled every CLKS_PER_BIT cycles, LSB first, into a shift register; after WORD_SIZE samples the FSM goes to PARITY (macro on) or STOP (macro off).
REQ-011 In STOP, rxs sampled high SHALL accept the word and return to IDLE.
REQ-012 In STOP, rxs sampled low SHALL pulse frame_err, discard the word and go to WAIT_IDLE; WAIT_IDLE exits to IDLE only when rxs is high.
REQ-013 An accepted word SHALL be written at the tail one cycle after the stop sample, on the same edge the FSM leaves STOP.
REQ-014 An accepted word arriving with the ring full and no pop SHALL be dropped, pulse overflow, and leave ring contents unchanged.
REQ-015 data_out SHALL equal ring[head] whenever read_nic_i=1, and 0 when empty.
REQ-016 read_nic=1 with read_nic_i=1 SHALL advance head on that edge; read_nic while empty SHALL be ignored with no error.
REQ-017 A simultaneous push and pop SHALL both succeed, including when full (no overflow) and when the ring holds one word.
REQ-018 head and tail SHALL be log2(RX_RING_SIZE) bits and wrap naturally; the occupancy count SHALL be log2(RX_RING_SIZE)+1 bits.
REQ-019 read_nic_i SHALL be registered and reflect occupancy the cycle after any push or pop.

Reset
REQ-020 rst low SHALL immediately force: FSM to IDLE; timer, head, tail and count to 0; synchronizer flops to 1; all outputs to 0.
REQ-021 Reset mid-frame SHALL abandon the frame and the ring contents; after release the line SHALL be re-acquired only on a new falling edge.

Configuration
REQ-022 Defining UART_RX_PARITY_EN SHALL insert a PARITY state after DATA that samples one even-parity bit.
REQ-023 With UART_RX_PARITY_EN, a parity mismatch SHALL pulse parity_err in the cycle after the STOP-state sample, discard the word, and still check the stop bit for frame_err.
REQ-024 Without UART_RX_PARITY_EN, parity_err SHALL be tied to 0 and the frame SHALL be 1 start + WORD_SIZE data + 1 stop bits.

Structure
REQ-025 The shared UART parameters package SHALL hold WORD_SIZE_p, RX_RING_SIZE_p, CLKS_PER_BIT_p and the FSM state enum typedef.
REQ-026 The ring SHALL be a sub-module named uart_ring_fifo, reusable by the TX path; the FSM and bit-timer SHALL stay in uart_rx_ring.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Send 8'hA5 with correct framing -> read_nic_i rises within 2 cycles of stop mid-bit; data_out=8'hA5; one read_nic empties the ring.
- rx low for 100 clks then high -> no push, no frame_err, FSM back in IDLE.
- Send 8'h3C with stop bit 0 -> frame_err pulses once; ring stays empty; next valid 8'h11 is received correctly.
- Send 9 words 0x01..0x09 with no reads (depth 8) -> overflow pulses once on 0x09; reads return 0x01..0x08 in order, then read_nic_i=0.
- Ring full and a word accepted on the same cycle as read_nic -> no overflow; count stays 8; wrap-around order preserved.
- With UART_RX_PARITY_EN, send 8'h07 with parity bit 0 (odd ones, even parity expects 1) -> parity_err pulses; word discarded; rst low mid-frame clears all outputs at once.
